// File: rtl/poly_ring_pkg.sv
// poly_ring_pkg
//   Shared constants for the GF(2)[x]/(x^N_BITS-1) accumulator datapath and
//   the state type of the fold writer FSM.
//   No ports (package).
package poly_ring_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int N_BITS        = 17669;
  localparam int LAST_WORD_IDX = N_BITS / WORD_WIDTH;   // 552: partial top word
  localparam int LAST_BITS     = N_BITS % WORD_WIDTH;   // 5 valid bits in it
  localparam int ADDR_W        = 10;
  localparam int POS_W         = 15;                    // ring bit position width
  localparam int CNT_W         = 6;                     // 0..32 bits-consumed counter

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fold_seg_calc.sv
// fold_seg_calc
//   Combinational segment splitter. Given the current ring position p, the
//   number of word bits already consumed c and the source word, it computes
//   the RAM word touched by the next segment, how many bits fit there, the
//   bits to XOR into that RAM word, and where the following segment starts.
// Ports
//   p       in   POS_W       ring position of the first bit of this segment
//   c       in   CNT_W       source bits already consumed (0..32)
//   word    in   WORD_WIDTH  source word
//   addr    out  ADDR_W      RAM word index (p >> 5)
//   len     out  CNT_W       bits placed by this segment (0 when c == 32)
//   field   out  WORD_WIDTH  segment bits aligned to their RAM bit offset
//   p_next  out  POS_W       start position of the next segment (folded to 0)
//   c_next  out  CNT_W       c + len
//   wrap    out  1           segment ends at N_BITS and bits remain, so the
//                            next segment lands at word 0
module fold_seg_calc
  import poly_ring_pkg::*;
(
  input  logic [POS_W-1:0]      p,
  input  logic [CNT_W-1:0]      c,
  input  logic [WORD_WIDTH-1:0] word,
  output logic [ADDR_W-1:0]     addr,
  output logic [CNT_W-1:0]      len,
  output logic [WORD_WIDTH-1:0] field,
  output logic [POS_W-1:0]      p_next,
  output logic [CNT_W-1:0]      c_next,
  output logic                  wrap
);

  logic [4:0]            off;
  logic [CNT_W-1:0]      cap;
  logic [CNT_W-1:0]      rem;
  logic [WORD_WIDTH-1:0] mask;
  logic [WORD_WIDTH-1:0] shifted;
  logic [POS_W-1:0]      p_sum;

  assign addr = p[POS_W-1:5];
  assign off  = p[4:0];

  // The top word only holds LAST_BITS ring bits; never spill above them.
  assign cap = (addr == ADDR_W'(LAST_WORD_IDX)) ? (CNT_W'(LAST_BITS) - {1'b0, off})
                                                : (CNT_W'(WORD_WIDTH) - {1'b0, off});
  assign rem = CNT_W'(WORD_WIDTH) - c;
  assign len = (cap < rem) ? cap : rem;

  // Thermometer mask of len ones; len may be a full 32.
  generate
    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_mask
      assign mask[gi] = (CNT_W'(gi) < len);
    end
  endgenerate

  assign shifted = word >> c;
  assign field   = (shifted & mask) << off;

  assign p_sum  = p + POS_W'(len);
  assign c_next = c + len;
  assign p_next = (p_sum == POS_W'(N_BITS)) ? '0 : p_sum;
  // Reaching N_BITS exactly on the last bit of the word is not a fold.
  assign wrap   = (p_sum == POS_W'(N_BITS)) && (c_next != CNT_W'(WORD_WIDTH));

endmodule

// File: rtl/acc_wrap_fold_writer.sv
// acc_wrap_fold_writer
//   XOR-accumulates one 32-bit partial-product word into the accumulator RAM
//   at ring position in_bit_pos of GF(2)[x]/(x^N_BITS-1). The word is split
//   into 1..3 read-modify-write segments; bits passing position N_BITS-1 fold
//   back to word 0. Bits of the top word above LAST_BITS are never set.
// Optional feature macro: WRAP_COUNT_EN adds wrap_count, a saturating count
//   of words whose bits folded past N_BITS-1 into word 0.
// Ports
//   clk         in   1   clock
//   rst_n       in   1   asynchronous active-low reset
//   in_valid    in   1   input word valid
//   in_ready    out  1   high only while idle
//   in_word     in   32  bit i lands at (in_bit_pos + i) mod N_BITS
//   in_bit_pos  in   15  ring position of in_word[0]
//   mem_en      out  1   RAM access strobe
//   mem_we      out  1   1 = write, 0 = read
//   mem_addr    out  10  RAM word address
//   mem_wdata   out  32  write data (read data XOR segment field)
//   mem_rdata   in   32  read data, valid the cycle after a read strobe
//   done        out  1   pulse: all segments written
//   err_range   out  1   pulse: accepted position >= N_BITS, word dropped
//   wrap_count  out  16  (WRAP_COUNT_EN only) folded-word counter
module acc_wrap_fold_writer
  import poly_ring_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic [POS_W-1:0]      in_bit_pos,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  done,
  output logic                  err_range
`ifdef WRAP_COUNT_EN
  ,
  output logic [15:0]           wrap_count
`endif
);

  fsm_state_t            state_reg;
  logic [WORD_WIDTH-1:0] word_reg;
  logic [POS_W-1:0]      p_reg;        // start of the segment after the current one
  logic [CNT_W-1:0]      c_reg;        // bits consumed once the current segment is written
  logic [WORD_WIDTH-1:0] field_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic                  wrapped_reg;
  logic                  in_ready_reg;
  logic                  mem_en_reg;
  logic                  mem_we_reg;
  logic                  done_reg;
  logic                  err_reg;

  logic [POS_W-1:0]      calc_p;
  logic [CNT_W-1:0]      calc_c;
  logic [WORD_WIDTH-1:0] calc_word;
  logic [ADDR_W-1:0]     seg_addr;
  logic [CNT_W-1:0]      seg_len;
  logic [WORD_WIDTH-1:0] seg_field;
  logic [POS_W-1:0]      seg_p_next;
  logic [CNT_W-1:0]      seg_c_next;
  logic                  seg_wrap;
  logic                  last_seg;

  // While idle the calculator looks straight at the input so the first
  // segment address is ready to register on the accept edge.
  assign calc_p    = (state_reg == ST_IDLE) ? in_bit_pos : p_reg;
  assign calc_c    = (state_reg == ST_IDLE) ? '0         : c_reg;
  assign calc_word = (state_reg == ST_IDLE) ? in_word    : word_reg;

  fold_seg_calc u_seg_calc (
    .p      (calc_p),
    .c      (calc_c),
    .word   (calc_word),
    .addr   (seg_addr),
    .len    (seg_len),
    .field  (seg_field),
    .p_next (seg_p_next),
    .c_next (seg_c_next),
    .wrap   (seg_wrap)
  );

  assign last_seg = (c_reg == CNT_W'(WORD_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      word_reg     <= '0;
      p_reg        <= '0;
      c_reg        <= '0;
      field_reg    <= '0;
      addr_reg     <= '0;
      wrapped_reg  <= 1'b0;
      in_ready_reg <= 1'b1;
      mem_en_reg   <= 1'b0;
      mem_we_reg   <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready_reg) begin
            if (in_bit_pos >= POS_W'(N_BITS)) begin
              err_reg <= 1'b1;
            end else begin
              word_reg     <= in_word;
              addr_reg     <= seg_addr;
              field_reg    <= seg_field;
              p_reg        <= seg_p_next;
              c_reg        <= seg_c_next;
              wrapped_reg  <= seg_wrap;
              in_ready_reg <= 1'b0;
              mem_en_reg   <= 1'b1;
              mem_we_reg   <= 1'b0;
              state_reg    <= ST_RD;
            end
          end
        end
        ST_RD: begin
          mem_we_reg <= 1'b1;
          state_reg  <= ST_WR;
        end
        ST_WR: begin
          if (last_seg) begin
            mem_en_reg   <= 1'b0;
            mem_we_reg   <= 1'b0;
            in_ready_reg <= 1'b1;
            done_reg     <= 1'b1;
            state_reg    <= ST_IDLE;
          end else begin
            addr_reg    <= seg_addr;
            field_reg   <= seg_field;
            p_reg       <= seg_p_next;
            c_reg       <= seg_c_next;
            wrapped_reg <= wrapped_reg | seg_wrap;
            mem_we_reg  <= 1'b0;
            state_reg   <= ST_RD;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = addr_reg;
  // Read data arrives during the write cycle, so the merge is combinational.
  assign mem_wdata = (state_reg == ST_WR) ? (mem_rdata ^ field_reg) : '0;
  assign done      = done_reg;
  assign err_range = err_reg;

`ifdef WRAP_COUNT_EN
  logic [15:0] wrap_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_count_reg <= '0;
    end else if ((state_reg == ST_WR) && last_seg && wrapped_reg &&
                 (wrap_count_reg != 16'hFFFF)) begin
      wrap_count_reg <= wrap_count_reg + 16'd1;
    end
  end

  assign wrap_count = wrap_count_reg;
`endif

endmodule

// File: tb/tb_acc_wrap_fold_writer.sv
// tb_acc_wrap_fold_writer
//   Directed bench for acc_wrap_fold_writer with a behavioural ring model
//   (one bit per ring position) and a single-port RAM model. Build with
//   WRAP_COUNT_EN defined to also check wrap_count.
module tb_acc_wrap_fold_writer;

  localparam int N = 17669;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic [14:0] in_bit_pos = '0;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err_range;
`ifdef WRAP_COUNT_EN
  logic [15:0] wrap_count;
`endif

  always #5 clk = ~clk;

  acc_wrap_fold_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_bit_pos (in_bit_pos),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .done       (done),
    .err_range  (err_range)
`ifdef WRAP_COUNT_EN
    ,
    .wrap_count (wrap_count)
`endif
  );

  // RAM model; the bench port has priority and is used only while idle.
  logic [31:0] ram [0:1023];
  logic        bwr_en = 1'b0;
  logic [9:0]  bwr_addr = '0;
  logic [31:0] bwr_data = '0;

  always @(posedge clk) begin
    if (bwr_en) ram[bwr_addr] <= bwr_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Ring model and expected bus timeline keyed by absolute cycle number.
  bit ring [0:N-1];
  int wrap_exp = 0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc_count = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic        en;
    logic        we;
    logic        dn;
    logic        err;
    logic        rdy;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t tl [int];

  always @(posedge clk) cyc_count <= cyc_count + 1;

  function automatic logic [31:0] golden(input int w);
    logic [31:0] g;
    g = '0;
    for (int b = 0; b < 32; b++) begin
      if (w * 32 + b < N) g[b] = ring[w * 32 + b];
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, outputs against the expected timeline.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en) begin
      e = '0;
      e.rdy = 1'b1;
      if (tl.exists(cyc_count)) e = tl[cyc_count];
      chk("in_ready", 32'(in_ready), 32'(e.rdy));
      chk("mem_en", 32'(mem_en), 32'(e.en));
      chk("done", 32'(done), 32'(e.dn));
      chk("err_range", 32'(err_range), 32'(e.err));
      if (e.en) begin
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
  end

  task automatic clear_mem();
    for (int w = 0; w <= 552; w++) begin
      @(negedge clk);
      bwr_en = 1'b1; bwr_addr = 10'(w); bwr_data = '0;
    end
    @(negedge clk);
    bwr_en = 1'b0;
    for (int i = 0; i < N; i++) ring[i] = 1'b0;
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    @(negedge clk);
    bwr_en = 1'b1; bwr_addr = 10'(w); bwr_data = d;
    @(negedge clk);
    bwr_en = 1'b0;
    for (int b = 0; b < 32; b++) if (w * 32 + b < N) ring[w * 32 + b] = d[b];
  endtask

  // Called at a negedge; returns at the negedge of the done (or error) cycle.
  task automatic run_txn(input int pos, input logic [31:0] word, input bit spam, output int segs);
    int   c0, last, b, w;
    int   waddr[$];
    bit   wrapped;
    exp_t e;
    in_valid = 1'b1; in_word = word; in_bit_pos = 15'(pos);
    c0 = cyc_count;
    segs = 0;
    if (pos >= N) begin
      e = '0; e.err = 1'b1; e.rdy = 1'b1;
      tl[c0 + 1] = e;
      $display("[TB] txn pos=%0d word=0x%08h out of range", pos, word);
      @(negedge clk);
      in_valid = 1'b0;
    end else begin
      last = -1; wrapped = 1'b0;
      for (int i = 0; i < 32; i++) begin
        b = pos + i;
        if (b >= N) begin b = b - N; wrapped = 1'b1; end
        w = b / 32;
        if (w != last) waddr.push_back(w);
        last = w;
        ring[b] ^= word[i];
      end
      segs = waddr.size();
      if (wrapped) wrap_exp++;
      for (int k = 0; k < segs; k++) begin
        e = '0; e.en = 1'b1; e.addr = 10'(waddr[k]);
        tl[c0 + 2 * k + 1] = e;
        e.we = 1'b1; e.wdata = golden(waddr[k]);
        tl[c0 + 2 * k + 2] = e;
      end
      e = '0; e.dn = 1'b1; e.rdy = 1'b1;
      tl[c0 + 2 * segs + 1] = e;
      $display("[TB] txn pos=%0d word=0x%08h segments=%0d wrap=%0d", pos, word, segs, wrapped);
      for (int n = 1; n <= 2 * segs + 1; n++) begin
        @(negedge clk);
        if (spam && n <= 2 * segs) begin
          in_valid = 1'b1; in_word = ~word; in_bit_pos = 15'((pos + 100) % N);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int s;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_range), 32'd0);
`ifdef WRAP_COUNT_EN
    chk("rst_wrap_count", 32'(wrap_count), 32'd0);
`endif
    clear_mem();
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: single aligned segment
    run_txn(0, 32'hDEADBEEF, 1'b0, s);
    chk("c1_segs", 32'(s), 32'd1);
    chk("c1_mem0", ram[0], 32'hDEADBEEF);

    // 2: two segments, busy-time in_valid ignored
    clear_mem();
    run_txn(40, 32'hFFFFFFFF, 1'b1, s);
    chk("c2_segs", 32'(s), 32'd2);
    chk("c2_mem1", ram[1], 32'hFFFFFF00);
    chk("c2_mem2", ram[2], 32'h000000FF);

    // 3: top word then fold into pre-loaded word 0
    clear_mem();
    preload(0, 32'h00000001);
    run_txn(17664, 32'hFFFFFFFF, 1'b0, s);
    chk("c3_segs", 32'(s), 32'd2);
    chk("c3_mem552", ram[552], 32'h0000001F);
    chk("c3_mem0", ram[0], 32'h07FFFFFE);

    // 4: three segments across 551, 552, 0
    clear_mem();
    run_txn(17660, 32'hFFFFFFFF, 1'b0, s);
    chk("c4_segs", 32'(s), 32'd3);
    chk("c4_mem551", ram[551], 32'hF0000000);
    chk("c4_mem552", ram[552], 32'h0000001F);
    chk("c4_mem0", ram[0], 32'h007FFFFF);
`ifdef WRAP_COUNT_EN
    chk("c34_wrap_count", 32'(wrap_count), 32'd2);
`endif

    // 5: out-of-range position
    run_txn(17669, 32'h12345678, 1'b0, s);
    chk("c5_segs", 32'(s), 32'd0);

    // Accumulating back-to-back words on top of case 4
    run_txn(17668, 32'hA5A5A5A5, 1'b0, s);
    run_txn(31, 32'h80000001, 1'b0, s);
    chk("acc_mem0", ram[0], 32'hD2AD2D2D);
    chk("acc_mem1", ram[1], 32'h40000000);
    chk("acc_mem552", ram[552], 32'h0000000F);
    run_txn(5000, 32'h0F0F0F0F, 1'b1, s);
    run_txn(32767, 32'hFFFFFFFF, 1'b0, s);
    run_txn(17638, 32'h3C3C3C3C, 1'b0, s);
    chk("c17638_segs", 32'(s), 32'd3);
    @(negedge clk);
    for (int w = 0; w <= 552; w++) chk($sformatf("image_w%0d", w), ram[w], golden(w));
`ifdef WRAP_COUNT_EN
    chk("wrap_count_model", 32'(wrap_count), 32'(wrap_exp));
`endif

    // 6: reset during the second write of case 4
    chk_en = 1'b0;
    clear_mem();
    in_valid = 1'b1; in_word = 32'hFFFFFFFF; in_bit_pos = 15'd17660;
    $display("[TB] txn pos=17660 word=0xffffffff reset during 2nd write");
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("c6_pre_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    chk("c6_pre_addr", 32'(mem_addr), 32'd552);
    rst_n = 1'b0;
    #1;
    chk("c6_rst_mem_en", 32'(mem_en), 32'd0);
    chk("c6_rst_done", 32'(done), 32'd0);
    chk("c6_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("c6_post_in_ready", 32'(in_ready), 32'd1);
    chk("c6_post_mem_en", 32'(mem_en), 32'd0);
    chk("c6_mem551", ram[551], 32'hF0000000);
    chk("c6_mem552", ram[552], 32'h00000000);
    chk("c6_mem0", ram[0], 32'h00000000);
`ifdef WRAP_COUNT_EN
    chk("c6_wrap_count", 32'(wrap_count), 32'd0);
    wrap_exp = 0;
`endif
    clear_mem();
    chk_en = 1'b1;
    run_txn(17660, 32'hFFFFFFFF, 1'b0, s);
    chk("c6_reissue_mem552", ram[552], 32'h0000001F);
    chk("c6_reissue_mem0", ram[0], 32'h007FFFFF);
`ifdef WRAP_COUNT_EN
    chk("c6_reissue_wrap_count", 32'(wrap_count), 32'(wrap_exp));
`endif
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
